raymarch_frame_scheduler: RTL and testbench
===========================================

RAYMARCH_FRAME_SCHEDULER -- requirements
Module: raymarch_frame_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- CORDW, 10, pixel coordinate width
- MAX_OUT, 4, maximum pixels in flight in the raymarcher (at least 1)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, the single clock
- rst_n, in, 1, asynchronous active-low reset
- cfg_we, in, 1, camera register write strobe
- cfg_addr, in, 4, register index: 0-2 eye_x/y/z; 3-11 look_at_1_1..look_at_3_3, row-major
- cfg_wdata, in, 27, write data
- frame_go, in, 1, request to render one frame
- pix_ready, in, 1, raymarcher accepts a pixel
- res_valid, in, 1, raymarcher completion pulse, one per pixel
- pix_valid, out, 1, pixel issue request
- pix_x, out, CORDW, pixel column
- pix_y, out, CORDW, pixel row
- cam_active, out, 324, active camera words; word k is at [27k+26:27k]
- busy, out, 1, frame in progress
- frame_done, out, 1, one-cycle frame completion pulse
- err_underflow, out, 1, sticky completion-without-outstanding error
- frame_cycles, out, 32, cycle count of the last frame

Function
REQ-003 The block SHALL implement an FSM with states IDLE, LATCH, ISSUE, DRAIN and DONE.
REQ-004 In IDLE, frame_go=1 SHALL move the FSM to LATCH; frame_go SHALL be ignored in every other state.
REQ-005 LATCH SHALL last 1 cycle: copy all 12 shadow registers to cam_active, set pix_x and pix_y to 0, then go to ISSUE.
REQ-006 pix_valid SHALL equal (state==ISSUE && outstanding<MAX_OUT), decoded from registers only.
REQ-007 Timing: first pix_valid=1 occurs 2 cycles after frame_go is sampled in IDLE.
REQ-008 A transfer occurs when pix_valid && pix_ready; pix_x/pix_y SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-009 Advance on each transfer:
- pix_x increments by 1.
- At pix_x==H_RES-1, pix_x wraps to 0 and pix_y increments.
- A transfer at (H_RES-1, V_RES-1) SHALL go to DRAIN with pix_x/pix_y held.
REQ-010 outstanding (width clog2(MAX_OUT+1)) SHALL update as:
- +1 on a transfer alone.
- -1 on res_valid alone.
- Unchanged when both occur in the same cycle.
REQ-011 res_valid while outstanding==0 (and no same-cycle transfer) SHALL leave outstanding at 0 and set err_underflow.
REQ-012 DRAIN SHALL go to DONE in the cycle after outstanding reaches 0.
REQ-013 DONE SHALL last 1 cycle with frame_done=1, then return to IDLE.
REQ-014 busy SHALL be 1 in LATCH, ISSUE, DRAIN and DONE.
REQ-015 Camera register writes:
- cfg_we with cfg_addr 0-11 SHALL write the shadow register in any state.
- cfg_addr 12-15 SHALL be ignored.
- cam_active SHALL change only in LATCH.
REQ-016 A cfg write in the same cycle as LATCH SHALL be captured into shadow only; the old shadow value is latched.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- FSM to IDLE.
- pix_valid, busy, frame_done, err_underflow to 0.
- pix_x, pix_y, outstanding, frame_cycles to 0.
- All shadow registers and cam_active to 0.
REQ-018 Reset mid-frame SHALL abandon the frame with no frame_done; completions arriving after reset SHALL raise err_underflow.

Configuration
REQ-019 With RM_SCHED_PERF_EN defined:
- A 32-bit counter SHALL clear in LATCH and increment every cycle through DONE inclusive, saturating at 2^32-1.
- frame_cycles SHALL load the counter's final value in DONE and hold it until the next DONE.
REQ-020 Without RM_SCHED_PERF_EN, frame_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Verification (H_RES=4, V_RES=2, MAX_OUT=2 unless stated)
REQ-021 pix_ready=1, res_valid 3 cycles after each transfer, frame_go pulse:
- Required response: 8 transfers in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
- pix_valid never exceeds 2 in flight.
- frame_done pulses once, after the 8th res_valid.
REQ-022 Write cfg_addr=3 data 27'h0400000, frame_go, then write addr 3 data 27'h1 mid-frame:
- Required response: cam_active[107:81]=27'h0400000 all frame.
- The next frame latches 27'h1.
- A write to addr 13 changes nothing.
REQ-023 pix_ready=0 for 5 cycles at (2,0): pix_x=2, pix_y=0 and pix_valid=1 SHALL hold all 5 cycles, with no advance.
REQ-024 Transfer and res_valid in the same cycle at outstanding=1: outstanding SHALL stay 1; a lone res_valid at outstanding=0 SHALL set err_underflow, which stays set until reset.
REQ-025 Assert rst_n=0 during ISSUE at (1,1): all outputs SHALL go to 0 immediately with no frame_done; a frame_go after release SHALL restart at (0,0).
REQ-026 RM_SCHED_PERF_EN defined, MAX_OUT=8, pix_ready=1, fixed 10-cycle core latency: frame_cycles SHALL equal the LATCH-to-DONE cycle count (bench-computed, 19), and SHALL read 0 when built without the macro.

Source files
------------

// File: rtl/raymarch_frame_scheduler.sv
// raymarch_frame_scheduler: issues one raster frame of pixels to a raymarch core, bounding work in
// flight and latching camera registers at frame start. Optional macro RM_SCHED_PERF_EN adds frame_cycles.
`default_nettype none

module raymarch_frame_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int CORDW   = 10,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [26:0]      cfg_wdata,
  input  logic             frame_go,
  input  logic             pix_ready,
  input  logic             res_valid,
  output logic             pix_valid,
  output logic [CORDW-1:0] pix_x,
  output logic [CORDW-1:0] pix_y,
  output logic [323:0]     cam_active,
  output logic             busy,
  output logic             frame_done,
  output logic             err_underflow,
  output logic [31:0]      frame_cycles
);

  localparam int OUTW = $clog2(MAX_OUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CORDW-1:0] X_LAST   = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] Y_LAST   = CORDW'(V_RES - 1);
  localparam logic [CORDW-1:0] CORD_ONE = CORDW'(1);
  localparam logic [OUTW-1:0]  OUT_MAX  = OUTW'(MAX_OUT);
  localparam logic [OUTW-1:0]  OUT_ONE  = OUTW'(1);

  logic [2:0]        state_q, state_d;
  logic [CORDW-1:0]  x_q, x_d;
  logic [CORDW-1:0]  y_q, y_d;
  logic [OUTW-1:0]   out_q, out_d;
  logic              err_q, err_d;
  logic [11:0][26:0] shadow_q;
  logic [11:0][26:0] cam_q;
  logic              xfer;

  assign pix_valid     = (state_q == S_ISSUE) && (out_q < OUT_MAX);
  assign xfer          = pix_valid && pix_ready;
  assign pix_x         = x_q;
  assign pix_y         = y_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign err_underflow = err_q;
  assign cam_active    = cam_q;

  // A completion with nothing outstanding is flagged rather than wrapping the counter.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (xfer && !res_valid) begin
      out_d = out_q + OUT_ONE;
    end else if (res_valid && !xfer) begin
      if (out_q == '0) begin
        err_d = 1'b1;
      end else begin
        out_d = out_q - OUT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (frame_go) state_d = S_LATCH;
      end
      S_LATCH: begin
        x_d     = '0;
        y_d     = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              state_d = S_DRAIN;
            end else begin
              x_d = '0;
              y_d = y_q + CORD_ONE;
            end
          end else begin
            x_d = x_q + CORD_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Shadow writes are accepted in every state; a write in LATCH lands here only, after the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (cfg_we && (cfg_addr < 4'd12)) begin
      shadow_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_q <= '0;
    end else if (state_q == S_LATCH) begin
      cam_q <= shadow_q;
    end
  end

`ifdef RM_SCHED_PERF_EN
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] fc_q, fc_d;

  // The DONE cycle itself is counted, so the captured value is the incremented one.
  always_comb begin
    cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : (cnt_q + 32'd1);
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    case (state_q)
      S_LATCH: cnt_d = '0;
      S_ISSUE, S_DRAIN: cnt_d = cnt_inc;
      S_DONE: begin
        cnt_d = cnt_inc;
        fc_d  = cnt_inc;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      fc_q  <= fc_d;
    end
  end

  assign frame_cycles = fc_q;
`else
  assign frame_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_raymarch_frame_scheduler.sv
// tb_raymarch_frame_scheduler: table, directed and randomized checks of the frame scheduler
// against a transaction-level model (raster order, in-flight bound, frame completion timing).
`default_nettype none

module tb_raymarch_frame_scheduler;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int MO   = 2;
  localparam int N    = H * V;
  localparam int PLAT = 10;
`ifdef RM_SCHED_PERF_EN
  // Transfers fill cycles 1..N after LATCH, the last result lands PLAT-1 cycles later,
  // DRAIN sees zero on the next cycle and DONE follows: counted cycles 1..DONE.
  localparam int EXP_FC = N + PLAT + 1;
`else
  localparam int EXP_FC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [26:0] cfg_wdata = '0;
  logic        frame_go = 1'b0, pix_ready = 1'b0, res_valid = 1'b0;
  logic        pix_valid, busy, frame_done, err_underflow;
  logic [9:0]  pix_x, pix_y;
  logic [323:0] cam_active;
  logic [31:0] frame_cycles;

  logic        frame_go_p = 1'b0, res_valid_p = 1'b0;
  logic        pix_valid_p, busy_p, frame_done_p, err_p;
  logic [9:0]  px_p, py_p;
  logic [323:0] cam_p;
  logic [31:0] fc_p;

  raymarch_frame_scheduler #(.H_RES(H), .V_RES(V), .CORDW(10), .MAX_OUT(MO)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .frame_go(frame_go), .pix_ready(pix_ready), .res_valid(res_valid), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .cam_active(cam_active), .busy(busy), .frame_done(frame_done),
    .err_underflow(err_underflow), .frame_cycles(frame_cycles));

  raymarch_frame_scheduler #(.H_RES(H), .V_RES(V), .CORDW(10), .MAX_OUT(8)) u_perf (
    .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_addr(4'd0), .cfg_wdata(27'd0),
    .frame_go(frame_go_p), .pix_ready(1'b1), .res_valid(res_valid_p), .pix_valid(pix_valid_p),
    .pix_x(px_p), .pix_y(py_p), .cam_active(cam_p), .busy(busy_p), .frame_done(frame_done_p),
    .err_underflow(err_p), .frame_cycles(fc_p));

  int n_cmp = 0;
  int n_bad = 0;
  int now = 0;

  bit m_on = 1'b0, m_started = 1'b0, auto_core = 1'b0;
  int m_idx = 0, m_infl = 0, m_go = 0, m_done = -1;
  int q_due[$];
  int qp_due[$];
  int lat_lo = 3, lat_hi = 3, last_due = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [26:0] data;
    int          chk;
    logic [26:0] exp;
  } vec_t;
  vec_t tbl[14];
  logic [323:0] e_cam;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic logic [26:0] cam_word(input int k);
    return cam_active[27*k +: 27];
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_idx = 0;
    m_infl = 0;
    m_done = -1;
  endtask

  // One clock: drive the emulated cores, check against the model, advance everything.
  task automatic step();
    bit ev, xm, xa, xp, rv, rvp;
    int t, due;
    t = now;
    if (auto_core) res_valid = (q_due.size() > 0) ? (q_due[0] <= t) : 1'b0;
    res_valid_p = (qp_due.size() > 0) ? (qp_due[0] <= t) : 1'b0;
    rv  = res_valid;
    rvp = res_valid_p;
    xa  = pix_valid && pix_ready;
    xp  = pix_valid_p;
    if (m_on) begin
      ev = m_started && (t >= m_go + 2) && (m_idx < N) && (m_infl < MO);
      check("pix_valid", 64'(pix_valid), 64'(ev));
      check("busy", 64'(busy), 64'(m_started && (t > m_go)));
      check("frame_done", 64'(frame_done), 64'(m_done == t));
      xm = ev && pix_ready;
      if (xm) begin
        check("pix_x", 64'(pix_x), 64'(m_idx % H));
        check("pix_y", 64'(pix_y), 64'(m_idx / H));
        m_idx++;
      end
      if (xm && !rv) m_infl++;
      else if (rv && !xm && m_infl > 0) m_infl--;
      if (m_started && t == m_done) m_started = 1'b0;
      else if (!m_started && frame_go) begin
        m_started = 1'b1;
        m_go = t;
        m_idx = 0;
        m_done = -1;
      end
    end
    @(posedge clk);
    #1;
    now++;
    if (auto_core) begin
      if (rv) void'(q_due.pop_front());
      if (xa) begin
        due = t + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        q_due.push_back(due);
        last_due = due;
        check("in_flight_bound", 64'(q_due.size() <= MO), 64'd1);
      end
    end
    if (rvp) void'(qp_due.pop_front());
    if (xp) qp_due.push_back(t + PLAT - 1);
    if (m_on && m_started && m_done < 0 && m_idx == N && m_infl == 0) m_done = now + 1;
  endtask

  task automatic do_reset();
    m_on = 1'b0;
    auto_core = 1'b0;
    frame_go = 1'b0;
    frame_go_p = 1'b0;
    pix_ready = 1'b0;
    res_valid = 1'b0;
    cfg_we = 1'b0;
    q_due.delete();
    qp_due.delete();
    last_due = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic go();
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
  endtask

  task automatic finish_frame(input bit rnd, input int wr_at, input logic [3:0] wa,
                              input logic [26:0] wd, input bit watch, input logic [26:0] wval);
    int g = 0;
    while ((m_done < 0 || now <= m_done) && g < 400) begin
      pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_we = (g == wr_at);
      cfg_addr = wa;
      cfg_wdata = wd;
      step();
      cfg_we = 1'b0;
      if (watch) check("cam_word3", 64'(cam_word(3)), 64'(wval));
      g++;
    end
    check("frame_completes", 64'(g < 400), 64'd1);
  endtask

  task automatic run_frame(input bit rnd, input int wr_at, input logic [3:0] wa,
                           input logic [26:0] wd, input bit watch, input logic [26:0] wval);
    go();
    finish_frame(rnd, wr_at, wa, wd, watch, wval);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [26:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int g;
    for (int k = 0; k < 12; k++) begin
      tbl[k].addr = 4'(k);
      tbl[k].data = 27'($urandom);
      tbl[k].chk  = k;
      tbl[k].exp  = tbl[k].data;
    end
    tbl[12] = '{addr: 4'd12, data: 27'h7FF_FFFF, chk: 0,  exp: tbl[0].data};
    tbl[13] = '{addr: 4'd15, data: 27'h555_5555, chk: 11, exp: tbl[11].data};

    // Reset state
    #12;
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    check("rst_pix_xy", 64'({pix_x, pix_y}), 64'd0);
    check("rst_frame_cycles", 64'(frame_cycles), 64'd0);
    check("rst_cam_zero", 64'(cam_active == '0), 64'd1);
    do_reset();

    // Full-speed frame, fixed 3-cycle core latency
    m_on = 1'b1; auto_core = 1'b1; lat_lo = 3; lat_hi = 3;
    run_frame(1'b0, -1, 4'd0, 27'd0, 1'b0, 27'd0);
    check("no_err_clean_frame", 64'(err_underflow), 64'd0);

    // Camera latch isolation: mid-frame write, next frame picks it up, bad address ignored
    cfg_write(4'd3, 27'h0400000);
    run_frame(1'b0, 3, 4'd3, 27'h1, 1'b1, 27'h0400000);
    run_frame(1'b0, -1, 4'd0, 27'd0, 1'b1, 27'h1);
    cfg_write(4'd13, 27'h7FF_FFFF);
    run_frame(1'b0, -1, 4'd0, 27'd0, 1'b1, 27'h1);
    e_cam = '0;
    e_cam[81 +: 27] = 27'h1;
    check("cam_all_after_addr13", 64'(cam_active == e_cam), 64'd1);

    // Table of register writes; a write during LATCH only reaches the shadow
    do_reset();
    m_on = 1'b1; auto_core = 1'b1;
    for (int i = 0; i < 14; i++) cfg_write(tbl[i].addr, tbl[i].data);
    run_frame(1'b0, 0, 4'd0, 27'h5A5A5A, 1'b0, 27'd0);
    for (int i = 0; i < 14; i++) check($sformatf("tbl_word%0d", tbl[i].chk),
                                       64'(cam_word(tbl[i].chk)), 64'(tbl[i].exp));
    run_frame(1'b0, -1, 4'd0, 27'd0, 1'b0, 27'd0);
    check("latch_write_next_frame", 64'(cam_word(0)), 64'h5A5A5A);

    // Randomized ready and core latency
    lat_lo = 1; lat_hi = 6;
    for (int f = 0; f < 6; f++) run_frame(1'b1, -1, 4'd0, 27'd0, 1'b0, 27'd0);
    check("no_err_random", 64'(err_underflow), 64'd0);

    // Back-pressure hold at (2,0)
    lat_lo = 3; lat_hi = 3;
    go();
    g = 0;
    while (!(pix_valid && pix_x == 10'd2 && pix_y == 10'd0) && g < 50) begin
      pix_ready = 1'b1;
      step();
      g++;
    end
    check("reach_2_0", 64'(g < 50), 64'd1);
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", 64'({pix_valid, pix_x, pix_y}), 64'({1'b1, 10'd2, 10'd0}));
    end
    finish_frame(1'b0, -1, 4'd0, 27'd0, 1'b0, 27'd0);

    // Same-cycle transfer+completion, then underflow
    do_reset();
    go();
    step();
    check("issue_start", 64'({pix_valid, pix_x}), 64'({1'b1, 10'd0}));
    pix_ready = 1'b1;
    step();
    check("after_first_xfer", 64'({pix_valid, pix_x}), 64'({1'b1, 10'd1}));
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("both_same_cycle", 64'({pix_valid, pix_x}), 64'({1'b1, 10'd2}));
    step();
    check("outstanding_kept_one", 64'(pix_valid), 64'd0);
    pix_ready = 1'b0;
    res_valid = 1'b1;
    step();
    step();
    res_valid = 1'b0;
    check("no_err_yet", 64'(err_underflow), 64'd0);
    check("valid_after_drain", 64'(pix_valid), 64'd1);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("err_set", 64'(err_underflow), 64'd1);
    check("outstanding_no_wrap", 64'(pix_valid), 64'd1);
    repeat (3) step();
    check("err_sticky", 64'(err_underflow), 64'd1);

    // Asynchronous reset mid-frame at (1,1), completion after release, then restart
    do_reset();
    check("err_cleared_by_reset", 64'(err_underflow), 64'd0);
    m_on = 1'b1; auto_core = 1'b1;
    go();
    g = 0;
    while (!(pix_valid && pix_x == 10'd1 && pix_y == 10'd1) && g < 50) begin
      pix_ready = 1'b1;
      step();
      g++;
    end
    check("reach_1_1", 64'(g < 50), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", 64'({pix_valid, busy, frame_done, err_underflow}), 64'd0);
    check("async_rst_xy", 64'({pix_x, pix_y}), 64'd0);
    check("async_rst_cam", 64'(cam_active == '0), 64'd1);
    m_on = 1'b0; auto_core = 1'b0; res_valid = 1'b0; pix_ready = 1'b0;
    q_due.delete(); last_due = 0;
    step();
    step();
    check("no_done_in_reset", 64'({frame_done, busy}), 64'd0);
    rst_n = 1'b1;
    step();
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    check("late_completion_err", 64'(err_underflow), 64'd1);
    model_reset();
    m_on = 1'b1; auto_core = 1'b1;
    run_frame(1'b0, -1, 4'd0, 27'd0, 1'b0, 27'd0);

    // Frame cycle counter on the deep-queue instance
    do_reset();
    check("perf_rst", 64'(fc_p), 64'd0);
    frame_go_p = 1'b1;
    step();
    frame_go_p = 1'b0;
    g = 0;
    while (!frame_done_p && g < 200) begin
      step();
      g++;
    end
    check("perf_frame_done", 64'(frame_done_p), 64'd1);
    step();
    check("perf_frame_cycles", 64'(fc_p), 64'(EXP_FC));
    repeat (3) step();
    check("perf_hold", 64'(fc_p), 64'(EXP_FC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
